// File: rtl/npc_branch_resolve.sv
// npc_branch_resolve: execute-side branch resolution and predictor training.
// Fetch-time predictions are queued in order; each execute-side resolution is
// checked against the queue head. The block produces the registered training
// and redirect pulses for the next-PC predictor. After a mispredict it enters
// a short recovery window in which wrong-path traffic is dropped.
module npc_branch_resolve #(
   parameter int DEPTH          = 4,
   parameter int DEPTH_W        = 2,
   parameter int RECOVER_CYCLES = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   input  logic                 pred_valid_i,
   output logic                 pred_ready_o,
   input  logic [31:0]          pred_pc_i,
   input  logic                 pred_taken_i,
   input  logic [31:0]          pred_target_i,
   input  logic                 res_valid_i,
   input  logic [31:0]          res_pc_i,
   input  logic                 res_taken_i,
   input  logic [31:0]          res_target_i,
   input  logic                 res_is_cond_i,
   input  logic                 res_is_call_i,
   input  logic                 res_is_ret_i,
   input  logic                 res_is_jmp_i,
   output logic                 branch_request_o,
   output logic                 branch_is_taken_o,
   output logic                 branch_is_not_taken_o,
   output logic [31:0]          branch_source_o,
   output logic [31:0]          branch_pc_o,
   output logic                 branch_is_call_o,
   output logic                 branch_is_ret_o,
   output logic                 branch_is_jmp_o,
   output logic [DEPTH_W:0]     fifo_level_o,
   output logic [15:0]          mispredict_cnt_o
);

   localparam int RCW = $clog2(RECOVER_CYCLES + 1);
   localparam logic [DEPTH_W:0] LVL_FULL = (DEPTH_W+1)'(DEPTH);

   typedef enum logic {S_IDLE, S_RECOVER} state_t;

   // Saturating increment for the mispredict counter.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Fall-through PC of a resolved instruction; wraps modulo 2^32.
   function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   state_t               state_q, state_d;
   logic [RCW-1:0]       rcnt_q, rcnt_d;

   logic [31:0]          pc_mem   [DEPTH];
   logic                 tkn_mem  [DEPTH];
   logic [31:0]          tgt_mem  [DEPTH];
   logic [DEPTH_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [DEPTH_W:0]     level_q;
   logic [15:0]          mispredict_cnt_q;

   logic                 res_en_p0;
   logic                 head_match_p0;
   logic                 mispredict_p0;
   logic                 push_p0;
   logic                 pop_p0;

   // Output decode of the FSM: fetch handshake and resolution enable.
   always_comb begin
      pred_ready_o = rst_ni && (state_q == S_IDLE) && (level_q < LVL_FULL);
      res_en_p0    = res_valid_i && (state_q == S_IDLE) && !flush_i;
   end

   // Stage p0: head comparison, mispredict detection, FIFO handshakes.
   always_comb begin
      head_match_p0 = (level_q != '0) && (pc_mem[rd_ptr_q] == res_pc_i);
      mispredict_p0 = 1'b0;
      if (res_en_p0) begin
         if (head_match_p0)
            mispredict_p0 = (tkn_mem[rd_ptr_q] != res_taken_i) ||
                            (res_taken_i && (tgt_mem[rd_ptr_q] != res_target_i));
         else
            mispredict_p0 = res_taken_i;
      end
      pop_p0  = res_en_p0 && head_match_p0;
      push_p0 = pred_valid_i && pred_ready_o && !flush_i;
   end

   // Next-state logic: flush wins, then mispredict, then recovery countdown.
   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      if (flush_i) begin
         state_d = S_IDLE;
         rcnt_d  = '0;
      end else if (mispredict_p0) begin
         state_d = S_RECOVER;
         rcnt_d  = RCW'(RECOVER_CYCLES);
      end else if (state_q == S_RECOVER) begin
         if (rcnt_q <= RCW'(1)) begin
            state_d = S_IDLE;
            rcnt_d  = '0;
         end else begin
            rcnt_d  = rcnt_q - RCW'(1);
         end
      end
   end

   // State register with recovery counter.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
      end
   end

   // FIFO pointers and occupancy; flush or mispredict empties the queue.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (flush_i || mispredict_p0) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_p0) wr_ptr_q <= wr_ptr_q + DEPTH_W'(1);
         if (pop_p0)  rd_ptr_q <= rd_ptr_q + DEPTH_W'(1);
         case ({push_p0, pop_p0})
            2'b10:   level_q <= level_q + (DEPTH_W+1)'(1);
            2'b01:   level_q <= level_q - (DEPTH_W+1)'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // FIFO storage; contents are only meaningful below the occupancy level.
   always_ff @(posedge clk_i) begin
      if (push_p0) begin
         pc_mem[wr_ptr_q]  <= pred_pc_i;
         tkn_mem[wr_ptr_q] <= pred_taken_i;
         tgt_mem[wr_ptr_q] <= pred_target_i;
      end
   end

   // Stage p1: registered training/redirect outputs and mispredict count.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         branch_request_o      <= 1'b0;
         branch_is_taken_o     <= 1'b0;
         branch_is_not_taken_o <= 1'b0;
         branch_source_o       <= '0;
         branch_pc_o           <= '0;
         branch_is_call_o      <= 1'b0;
         branch_is_ret_o       <= 1'b0;
         branch_is_jmp_o       <= 1'b0;
         mispredict_cnt_q      <= '0;
      end else begin
         branch_request_o      <= mispredict_p0;
         branch_is_taken_o     <= res_en_p0 && res_taken_i;
         branch_is_not_taken_o <= res_en_p0 && res_is_cond_i && !res_taken_i;
         if (res_en_p0) begin
            branch_source_o  <= res_pc_i;
            branch_pc_o      <= res_taken_i ? res_target_i : next_seq_pc(res_pc_i);
            branch_is_call_o <= res_is_call_i;
            branch_is_ret_o  <= res_is_ret_i;
            branch_is_jmp_o  <= res_is_jmp_i;
         end
         if (mispredict_p0)
            mispredict_cnt_q <= sat_inc16(mispredict_cnt_q);
      end
   end

   assign fifo_level_o     = level_q;
   assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: doc/npc_branch_resolve.md
Name: npc_branch_resolve

Overview:
- Branch resolution and predictor-training source; the execute-side counterpart of the next-PC predictor.
- Records each fetch-time prediction in an in-order FIFO and pops the head when execute resolves a branch, comparing predicted and actual outcome.
- Emits the one-cycle training/redirect pulses the predictor consumes: branch_request, taken/not-taken, source, target, call/ret/jmp.
- After a mispredict, enters a recovery window that discards wrong-path traffic.

Parameters:
DEPTH, 4, prediction FIFO entries (power of two)
DEPTH_W, 2, log2(DEPTH)
RECOVER_CYCLES, 2, cycles of wrong-path suppression after a mispredict (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
flush_i  in  1  pipeline flush (exception/fence); highest priority
pred_valid_i  in  1  fetch presents a prediction record
pred_ready_o  out  1  record accepted when valid&ready
pred_pc_i  in  32  PC of predicted branch instruction
pred_taken_i  in  1  predicted taken
pred_target_i  in  32  predicted target (ignored if not taken)
res_valid_i  in  1  execute resolves a control-flow instruction
res_pc_i  in  32  PC of resolved instruction
res_taken_i  in  1  actual direction (1 for jumps)
res_target_i  in  32  actual target
res_is_cond_i  in  1  conditional branch
res_is_call_i  in  1  call
res_is_ret_i  in  1  return
res_is_jmp_i  in  1  unconditional jump (non call/ret)
branch_request_o  out  1  mispredict: redirect and BTB learn
branch_is_taken_o  out  1  resolved taken
branch_is_not_taken_o  out  1  resolved not-taken conditional
branch_source_o  out  32  = res_pc
branch_pc_o  out  32  redirect PC: res_target if taken, else res_pc+4
branch_is_call_o / branch_is_ret_o / branch_is_jmp_o  out  1 each  registered copies
fifo_level_o  out  DEPTH_W+1  occupancy
mispredict_cnt_o  out  16  mispredict count, saturating

Behaviour:
- Reset (rst_ni=0 at posedge): FIFO empty, state IDLE, recovery counter 0, all outputs 0. pred_ready_o=0 while reset is sampled low.
- pred_ready_o = (state==IDLE) & (level<DEPTH). When full, ready stays 0 even if a pop occurs in the same cycle.
- Push on valid&ready: {pc, taken, target} written at tail.
- Resolution is active only when res_valid_i, state==IDLE and ~flush_i.
  - Matched: FIFO non-empty and head.pc==res_pc_i. Head pops.
    - mispredict = (head.taken != res_taken_i) | (res_taken_i & head.target != res_target_i).
  - Unmatched: empty or PC differs. Treated as predicted not-taken; nothing pops.
    - mispredict = res_taken_i.
- Outputs are registered, with latency 1 cycle from the resolution sample. Pulses are high for exactly one cycle, otherwise 0.
  - branch_is_taken_o = res_taken_i.
  - branch_is_not_taken_o = res_is_cond_i & ~res_taken_i.
  - branch_request_o = mispredict.
  - source, pc and type outputs are updated on every active resolution and hold otherwise.
- Arithmetic: res_pc+4 is computed mod 2^32.
- Mispredict at an edge:
  - FIFO cleared; this overrides any same-cycle push and pop.
  - state -> RECOVER, counter = RECOVER_CYCLES.
  - mispredict_cnt_o increments, saturating at 0xFFFF.
- State RECOVER:
  - pred_ready_o=0 and resolutions ignored (no outputs).
  - Counter decrements each cycle; exits to IDLE on the edge where it reaches 0.
  - Exactly RECOVER_CYCLES cycles are suppressed.
- Simultaneous push+pop in IDLE with no mispredict: level unchanged, FIFO order preserved; pointers wrap mod DEPTH.
- flush_i at an edge:
  - FIFO cleared, state -> IDLE, counter 0.
  - Same-cycle push and resolution discarded; next-cycle pulses 0.
  - mispredict_cnt_o unchanged.
- Reset mid-RECOVER or with FIFO non-empty: returns fully to reset state. mispredict_cnt_o cleared only by reset.

Test Plan:
1. Correct prediction:
   - Stimulus: push {pc=0x100, taken=1, tgt=0x200}, then resolve pc=0x100, taken=1, tgt=0x200, cond.
   - Required response: next cycle taken_o=1, request_o=0; level 1->0; cnt=0.
2. Direction mispredict:
   - Stimulus: push {0x104, taken=0}, then resolve 0x104, taken=1, tgt=0x300.
   - Required response: request_o=1, branch_pc_o=0x300, source=0x104; FIFO emptied; pred_ready_o=0 for 2 cycles, then 1; cnt=1.
3. Unpredicted not-taken, empty FIFO:
   - Stimulus: resolve pc=0x40, taken=0, cond.
   - Required response: not_taken_o=1, request_o=0, branch_pc_o=0x44; level stays 0.
4. Full FIFO:
   - Stimulus: 4 pushes (0x10..0x1C), then pred_valid_i with a matched resolve of 0x10 in the same cycle.
   - Required response: pred_ready_o=0; after the pop, level=3 and ready=1.
5. Flush and wrong-path suppression:
   - Stimulus (flush): push 2 records, then flush_i together with res_valid_i.
   - Required response (flush): next cycle all pulses 0, level=0.
   - Stimulus (recovery): mispredict followed by res_valid_i during RECOVER.
   - Required response (recovery): no pulses during RECOVER.
6. Reset mid-RECOVER with 0xFFFF saturation preloaded:
   - Stimulus: preload the counter to 0xFFFF, trigger a mispredict, then assert rst_ni=0 for 1 cycle during RECOVER.
   - Required response: mispredict_cnt_o holds 0xFFFF after the mispredict. After reset: all outputs 0, cnt=0, state IDLE, ready=1.
